// File: rtl/led_blink_scheduler.sv
// Shares one status LED among NUM_REQ requesters, playing each request as a burst of timed blinks.
// Define LED_SCHED_HEARTBEAT_EN to get an idle heartbeat on led (HB_TICKS ticks per half-period).
module led_blink_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TICK_DIV  = 2500000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned GAP_TICKS = 8,
    parameter int unsigned HB_TICKS  = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   count,
    output logic                   led,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy
);

    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_A     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAX_B     = (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TMR_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t              state;
    logic [PRE_W-1:0]    presc;
    logic [TMR_W-1:0]    timer;
    logic [4:0]          pulse_cnt;
    logic [IDX_W-1:0]    ptr;

    logic                tick_c;
    logic                phase_end_c;
    logic                arb_found_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic [3:0]          arb_cnt_c;

    assign tick_c = (presc == PRE_W'(TICK_DIV - 1));

`ifdef LED_SCHED_HEARTBEAT_EN
    logic hb_end_c;
    assign hb_end_c = tick_c && (timer == TMR_W'(HB_TICKS - 1));
`endif

    // Round-robin search starting one past the last granted index
    always_comb begin
        int unsigned cand;
        cand        = 0;
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        arb_cnt_c   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!arb_found_c && req[IDX_W'(cand)]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = IDX_W'(cand);
                arb_cnt_c   = 4'(count >> (4 * cand));
            end
        end
    end

    always_comb begin
        phase_end_c = 1'b0;
        case (state)
            S_ON:    phase_end_c = tick_c && (timer == TMR_W'(ON_TICKS - 1));
            S_OFF:   phase_end_c = tick_c && (timer == TMR_W'(OFF_TICKS - 1));
            S_GAP:   phase_end_c = tick_c && (timer == TMR_W'(GAP_TICKS - 1));
            default: phase_end_c = 1'b0;
        endcase
    end

    // Phase sequencer; prescaler and phase timer restart on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            presc     <= '0;
            timer     <= '0;
            pulse_cnt <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            led       <= 1'b0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            done  <= '0;
            presc <= tick_c ? '0 : presc + PRE_W'(1);
            if (tick_c) begin
                timer <= timer + TMR_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (arb_found_c) begin
                        state     <= S_ON;
                        grant     <= NUM_REQ'(1) << arb_idx_c;
                        busy      <= 1'b1;
                        led       <= 1'b1;
                        ptr       <= arb_idx_c;
                        pulse_cnt <= (arb_cnt_c == 4'd0) ? 5'd16 : {1'b0, arb_cnt_c};
                        presc     <= '0;
                        timer     <= '0;
                    end else begin
`ifdef LED_SCHED_HEARTBEAT_EN
                        if (hb_end_c) begin
                            led   <= ~led;
                            timer <= '0;
                        end
`else
                        timer <= '0;
`endif
                    end
                end
                S_ON: begin
                    if (phase_end_c) begin
                        led       <= 1'b0;
                        presc     <= '0;
                        timer     <= '0;
                        pulse_cnt <= pulse_cnt - 5'd1;
                        state     <= (pulse_cnt == 5'd1) ? S_GAP : S_OFF;
                    end
                end
                S_OFF: begin
                    if (phase_end_c) begin
                        led   <= 1'b1;
                        presc <= '0;
                        timer <= '0;
                        state <= S_ON;
                    end
                end
                S_GAP: begin
                    if (phase_end_c) begin
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        led   <= 1'b0;
                        presc <= '0;
                        timer <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: directed scenarios plus random traffic against a waveform-level model.
// Build with LED_SCHED_HEARTBEAT_EN defined to exercise the idle heartbeat.
module tb_led_blink_scheduler;

    localparam int NR   = 4;
    localparam int TD   = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 1;
    localparam int GAPT = 3;
    localparam int HBT  = 5;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic [NR-1:0]     req   = '0;
    logic [4*NR-1:0]   count = '0;
    logic              led;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;

    logic [9:0] obs_v;
    logic [9:0] exp_v;
    int n_cmp = 0;
    int n_bad = 0;

    assign obs_v = {led, busy, grant, done};

    led_blink_scheduler #(
        .NUM_REQ  (NR),
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT),
        .GAP_TICKS(GAPT),
        .HB_TICKS (HBT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .count(count),
        .led  (led),
        .grant(grant),
        .done (done),
        .busy (busy)
    );

    initial forever #5 clk = ~clk;

    // Reference model: a code is a waveform indexed by cycles since the grant edge
    bit            m_active = 1'b0;
    int            m_ptr    = NR - 1;
    int            m_idx    = 0;
    int            m_n      = 0;
    int            m_pos    = 0;
    int            m_idle   = 0;
    logic [NR-1:0] m_done   = '0;

    function automatic int code_len(int n);
        return n * ONT * TD + (n - 1) * OFFT * TD + GAPT * TD;
    endfunction

    function automatic logic led_at(int pos, int n);
        int per;
        per = (ONT + OFFT) * TD;
        if (pos >= n * per - OFFT * TD) return 1'b0;
        return (pos % per) < ONT * TD;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = NR - 1;
            m_done   = '0;
            m_idle   = 0;
            m_pos    = 0;
        end else if (m_active) begin
            m_pos++;
            if (m_pos == code_len(m_n)) begin
                m_active       = 1'b0;
                m_done         = '0;
                m_done[m_idx]  = 1'b1;
                m_idle         = 0;
            end
        end else begin
            bit found;
            int c;
            found  = 1'b0;
            m_done = '0;
            for (int off = 1; off <= NR; off++) begin
                int cand;
                cand = (m_ptr + off) % NR;
                if (!found && req[cand]) begin
                    found = 1'b1;
                    m_idx = cand;
                end
            end
            if (found) begin
                m_active = 1'b1;
                m_ptr    = m_idx;
                m_pos    = 0;
                c        = int'(count[4*m_idx +: 4]);
                m_n      = (c == 0) ? 16 : c;
            end else begin
                m_idle++;
            end
        end
    end

    function automatic logic [9:0] model_exp();
        logic          l;
        logic [NR-1:0] g;
        l = 1'b0;
        g = '0;
        if (m_active) begin
            g[m_idx] = 1'b1;
            l        = led_at(m_pos, m_n);
        end else begin
`ifdef LED_SCHED_HEARTBEAT_EN
            l = ((m_idle / (HBT * TD)) % 2) == 1;
`endif
        end
        return {l, m_active, g, m_done};
    endfunction

    function automatic int onehot_idx(logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        req   = '0;
        count = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_v !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_async got %b expected %b", obs_v, 10'b0);
        end
        @(negedge clk);
        n_cmp++;
        if (obs_v !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_held got %b expected %b", obs_v, 10'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int gcyc, dcyc, highs, rises;
        logic pled;
        do_reset();
        gcyc = -1; dcyc = -1; highs = 0; rises = 0; pled = 1'b0;
        req   = 4'b0010;
        count = 16'h0030;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL single_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if (gcyc < 0 && grant !== '0) begin
                gcyc = c;
                req  = '0;
            end
            if (busy === 1'b1 && led === 1'b1) highs++;
            if (busy === 1'b1 && led === 1'b1 && pled === 1'b0) rises++;
            pled = led;
            if (dcyc < 0 && done[1] === 1'b1) begin
                dcyc = c;
                n_cmp++;
                if (grant !== '0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_done_idle grant=%b busy=%b expected 0000/0", grant, busy);
                end
            end
        end
        n_cmp++;
        if (gcyc < 0 || dcyc < 0 || dcyc - gcyc != 44) begin
            n_bad++;
            $display("FAIL single_done_latency grant_c=%0d done_c=%0d expected done 44 cycles after grant", gcyc, dcyc);
        end
        n_cmp++;
        if (highs != 24) begin
            n_bad++;
            $display("FAIL single_high_cycles got %0d expected 24", highs);
        end
        n_cmp++;
        if (rises != 3) begin
            n_bad++;
            $display("FAIL single_pulses got %0d expected 3", rises);
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        int exp_seq[4];
        int idle_run;
        logic [NR-1:0] pg;
        exp_seq = '{0, 1, 3, 0};
        do_reset();
        count = 16'h1111;
        req   = 4'b1011;
        pg = '0; idle_run = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL rr_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if (grant !== '0 && pg === '0) begin
                if (seq.size() > 0) begin
                    n_cmp++;
                    if (idle_run != 1) begin
                        n_bad++;
                        $display("FAIL rr_idle_gap got %0d expected 1", idle_run);
                    end
                end
                seq.push_back(onehot_idx(grant));
                idle_run = 0;
            end else if (busy === 1'b0) begin
                idle_run++;
            end
            pg = grant;
            if (seq.size() == 4) break;
        end
        req = '0;
        n_cmp++;
        if (seq.size() != 4) begin
            n_bad++;
            $display("FAIL rr_grant_count got %0d expected 4", seq.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < seq.size()) begin
                n_cmp++;
                if (seq[i] != exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d] got %0d expected %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL rr_drain c=%0d got %b expected %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_count_zero();
        int rises;
        bit seen;
        logic pled;
        do_reset();
        rises = 0; seen = 1'b0; pled = 1'b0;
        count = 16'h0000;
        req   = 4'b0001;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL zero_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if (grant !== '0) req = '0;
            if (busy === 1'b1 && led === 1'b1 && pled === 1'b0) rises++;
            pled = led;
            if (done[0] === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || rises != 16) begin
            n_bad++;
            $display("FAIL zero_count pulses=%0d done=%0d expected 16 pulses then done", rises, seen);
        end
    endtask

    task automatic test_mid_change();
        int rises;
        bit seen, chg;
        logic pled;
        do_reset();
        rises = 0; seen = 1'b0; chg = 1'b0; pled = 1'b0;
        count = 16'h0400;
        req   = 4'b0100;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL midchg_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if (busy === 1'b1 && led === 1'b1 && pled === 1'b0) rises++;
            pled = led;
            if (rises == 2 && !chg) begin
                req   = '0;
                count = 16'h0100;
                chg   = 1'b1;
            end
            if (done[2] === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || rises != 4) begin
            n_bad++;
            $display("FAIL midchg_complete pulses=%0d done=%0d expected 4 pulses then done", rises, seen);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic pled;
        do_reset();
        found = 1'b0; pled = 1'b0;
        count = 16'h0300;
        req   = 4'b0100;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if (grant !== '0) req = '0;
            if (busy === 1'b1 && pled === 1'b1 && led === 1'b0) begin
                found = 1'b1;
                break;
            end
            pled = led;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rstmid_reach_off got none expected OFF phase within 100 cycles");
        end
        req = 4'b0101;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_v !== 10'b0) begin
            n_bad++;
            $display("FAIL rstmid_immediate got %b expected %b", obs_v, 10'b0);
        end
        @(negedge clk);
        exp_v = model_exp();
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL rstmid_held got %b expected %b", obs_v, exp_v);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstmid_first_grant got %b expected 0001", grant);
        end
        req = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_drain c=%0d got %b expected %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_heartbeat();
        int first_hi, first_lo, highs;
        do_reset();
        first_hi = -1; first_lo = -1; highs = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL hb_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if (led === 1'b1) highs++;
            if (first_hi < 0 && led === 1'b1) first_hi = c;
            if (first_hi >= 0 && first_lo < 0 && led === 1'b0) first_lo = c;
        end
`ifdef LED_SCHED_HEARTBEAT_EN
        n_cmp++;
        if (first_hi != 20 || first_lo != 40) begin
            n_bad++;
            $display("FAIL hb_toggle rise=%0d fall=%0d expected 20/40", first_hi, first_lo);
        end
`else
        n_cmp++;
        if (highs != 0) begin
            n_bad++;
            $display("FAIL hb_idle_dark high_cycles=%0d expected 0", highs);
        end
`endif
        count = 16'h0001;
        req   = 4'b0001;
        @(negedge clk);
        req = '0;
        n_cmp++;
        if (led !== 1'b1 || grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL hb_override led=%b grant=%b expected 1/0001", led, grant);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL hb_after c=%0d got %b expected %b", c, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            exp_v = model_exp();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL random_cycle c=%0d got %b expected %b", c, obs_v, exp_v);
            end
            if ($urandom_range(7, 0) == 0) req = 4'($urandom);
            if ($urandom_range(3, 0) == 0) count = 16'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_count_zero();
        test_mid_change();
        test_reset_mid();
        test_heartbeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
